coreaxi4dma_start_op_arbiter: RTL and testbench
===============================================

// Module: coreaxi4dma_start_op_arbiter
// PURPOSE
//   Consumes the one-cycle per-descriptor start pulses (startDMAOp) produced by the control
//   register block. Queues one pending request per internal buffer descriptor (BD) and
//   round-robin arbitrates among BDs that are not already running. Issues one BD index at a
//   time to the DMA transfer engine over a valid/ready handshake. Tracks each BD as busy
//   until the engine reports completion.
// PARAMETERS
//   NUM_INT_BDS   4   number of internal BDs, 1..32; width of every per-BD vector
//   IDX_WIDTH     2   width of BD index ports; must be >= clog2(NUM_INT_BDS), min 1
// PORTS
//   clock        in   1            block clock; all logic on its rising edge
//   resetn       in   1            synchronous active-low reset
//   startDMAOp   in   NUM_INT_BDS  start pulses from control registers; bit i = start BD i
//   reqValid     out  1            BD request offered to the engine
//   reqIdx       out  IDX_WIDTH    BD index offered; valid when reqValid=1
//   reqReady     in   1            engine accepts; handshake = reqValid & reqReady
//   opDone       in   1            engine finished a BD (one-cycle pulse)
//   opDoneIdx    in   IDX_WIDTH    index of the finished BD
//   pending      out  NUM_INT_BDS  BD has a queued start not yet granted
//   busy         out  NUM_INT_BDS  BD granted to the engine, completion not yet seen
//   overrun      out  NUM_INT_BDS  sticky: start arrived while already pending (see CONFIGURATION)
//   overrunClr   in   NUM_INT_BDS  clears overrun bits
// BEHAVIOUR
//   Reset (resetn=0 at an edge):
//     - reqValid, reqIdx, pending, busy and overrun are all cleared to 0.
//     - The round-robin pointer is set to NUM_INT_BDS-1, so BD0 has first priority.
//     - Reset mid-operation discards all queued, offered and busy state; no completion is expected.
//   Pending tracking:
//     - pending[i] is set in the cycle after startDMAOp[i]=1.
//     - pending[i] is cleared in the cycle after its handshake.
//     - A start and a grant of the same BD in the same cycle: set wins, so a new request is queued.
//     - A start on a BD that is already pending is merged (only one request remains).
//   Eligibility: eligible = pending & ~busy. A started BD that is busy waits until its completion.
//   FSM:
//     - IDLE: reqValid=0. If eligible != 0, select the first eligible index searching upward
//       from ptr+1 with wrap-around. Register it into reqIdx, set reqValid=1 and go to OFFER.
//     - OFFER: reqValid=1 and reqIdx are held stable. reqValid is never withdrawn, even if that
//       BD gets a new start.
//       On handshake: clear pending[reqIdx], set busy[reqIdx], ptr<=reqIdx, reqValid<=0, go to IDLE.
//   Latency:
//     - Start pulse at cycle N gives pending at N+1 and, if idle and eligible, reqValid at N+2.
//     - After a handshake at cycle M, the next reqValid is no earlier than M+2.
//   Completion:
//     - opDone with opDoneIdx=i clears busy[i] in the next cycle.
//     - opDone for a BD that is not busy, or with opDoneIdx >= NUM_INT_BDS, is ignored.
//     - If the handshake and opDone name the same index in one cycle, set (busy) wins.
//   Index arithmetic:
//     - ptr+1 wraps from NUM_INT_BDS-1 to 0.
//     - Unused high bits of reqIdx are 0.
// CONFIGURATION
//   Macro: COREAXI4DMA_START_OVERRUN_EN.
//   Defined:
//     - overrun[i] is set when startDMAOp[i]=1 while pending[i]=1 and pending[i] is not being
//       cleared by a handshake that cycle.
//     - overrun[i] is cleared by overrunClr[i]=1; if set and clear coincide, set wins.
//   Undefined:
//     - No overrun storage exists; overrun is tied to 0 and overrunClr is ignored.
// TESTING
//   1. Reset, then startDMAOp=4'b0001 for 1 cycle at N -> reqValid=1, reqIdx=0 at N+2.
//      reqReady=1 -> pending=0, busy=4'b0001. opDone, idx 0 -> busy=0.
//   2. startDMAOp=4'b1011 in one cycle, reqReady held at 1, no opDone -> grants in order 0, 1, 3,
//      each 2 cycles apart; busy=4'b1011.
//   3. BD2 busy, then startDMAOp=4'b0100 -> pending[2]=1 but reqValid stays 0.
//      opDone, idx 2 -> reqValid=1, reqIdx=2 two cycles later.
//   4. reqValid=1, reqIdx=1 and reqReady=0 for 5 cycles while startDMAOp=4'b0001 arrives ->
//      reqIdx stays 1. Handshake; BD0 is offered next.
//   5. Macro defined: start BD3 twice while pending -> overrun=4'b1000. overrunClr[3] -> 0.
//      Macro undefined -> overrun stays 0.
//   6. Drop resetn while in OFFER with busy=4'b0110 -> all outputs 0 next cycle. opDone after
//      that is ignored.

Source files
------------

// File: rtl/coreaxi4dma_start_op_arbiter.sv
// ---------------------------------------------------------------------------
// coreaxi4dma_start_op_arbiter
//
// Collects one-cycle per-BD start pulses from the control register block,
// keeps one pending request per internal buffer descriptor, and round-robin
// arbitrates among pending BDs that are not already running. The winning BD
// index is offered to the DMA transfer engine one at a time. A BD stays busy
// from its grant until the engine reports it done.
//
// Optional feature: define COREAXI4DMA_START_OVERRUN_EN to build the sticky
// per-BD overrun flags. Without it, overrun reads 0 and overrunClr is ignored.
//
// Handshake: reqValid/reqIdx form a valid/ready source. Once reqValid rises,
// it and reqIdx hold stable until reqValid & reqReady at a rising edge, which
// is the one and only transfer point. reqValid is never withdrawn early.
//
// Ports
//   clock       in   block clock, rising edge
//   resetn      in   synchronous active-low reset
//   startDMAOp  in   [NUM_INT_BDS] start pulses, bit i starts BD i
//   reqValid    out  BD request offered to the engine
//   reqIdx      out  [IDX_WIDTH] offered BD index
//   reqReady    in   engine accepts the offer
//   opDone      in   engine finished a BD (one-cycle pulse)
//   opDoneIdx   in   [IDX_WIDTH] index of the finished BD
//   pending     out  [NUM_INT_BDS] queued start not yet granted
//   busy        out  [NUM_INT_BDS] granted, completion not yet seen
//   overrun     out  [NUM_INT_BDS] sticky: start arrived while pending
//   overrunClr  in   [NUM_INT_BDS] clears overrun bits
//   dbg_state   out  FSM state (0 = IDLE, 1 = OFFER)
// ---------------------------------------------------------------------------
module coreaxi4dma_start_op_arbiter #(
  parameter int NUM_INT_BDS = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_INT_BDS-1:0] startDMAOp,
  output logic                   reqValid,
  output logic [IDX_WIDTH-1:0]   reqIdx,
  input  logic                   reqReady,
  input  logic                   opDone,
  input  logic [IDX_WIDTH-1:0]   opDoneIdx,
  output logic [NUM_INT_BDS-1:0] pending,
  output logic [NUM_INT_BDS-1:0] busy,
  output logic [NUM_INT_BDS-1:0] overrun,
  input  logic [NUM_INT_BDS-1:0] overrunClr,
  output logic                   dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_WIDTH-1:0]   r_req_idx;
  logic [IDX_WIDTH-1:0]   w_req_idx_nxt;
  logic [IDX_WIDTH-1:0]   r_ptr;
  logic [IDX_WIDTH-1:0]   w_ptr_nxt;
  logic [NUM_INT_BDS-1:0] r_pending;
  logic [NUM_INT_BDS-1:0] r_busy;
  logic [NUM_INT_BDS-1:0] w_eligible;
  logic [NUM_INT_BDS-1:0] w_grant_mask;
  logic [NUM_INT_BDS-1:0] w_done_mask;
  logic                   w_hs;
  logic                   w_found;
  logic [IDX_WIDTH-1:0]   w_sel_idx;
  int                     w_dist;
  int                     w_best_dist;

  assign w_hs       = (r_state == ST_OFFER) && reqReady;
  assign w_eligible = r_pending & ~r_busy;
  assign w_found    = |w_eligible;

  // One-hot views of the grant and of the completion. An opDoneIdx beyond
  // the last BD matches no bit and so is ignored.
  always_comb begin
    w_grant_mask = '0;
    w_done_mask  = '0;
    for (int i = 0; i < NUM_INT_BDS; i++) begin
      w_grant_mask[i] = w_hs && (int'(r_req_idx) == i);
      w_done_mask[i]  = opDone && (int'(opDoneIdx) == i);
    end
  end

  // Round-robin pick: distance of BD i from ptr+1 going upward with wrap;
  // the eligible BD with the smallest distance wins.
  always_comb begin
    w_sel_idx   = '0;
    w_dist      = 0;
    w_best_dist = NUM_INT_BDS;
    for (int i = 0; i < NUM_INT_BDS; i++) begin
      w_dist = (i + 2 * NUM_INT_BDS - int'(r_ptr) - 1) % NUM_INT_BDS;
      if (w_eligible[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_sel_idx   = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_req_idx_nxt = r_req_idx;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt   = ST_OFFER;
          w_req_idx_nxt = w_sel_idx;
        end
      end
      ST_OFFER: begin
        if (w_hs) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = r_req_idx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_req_idx <= '0;
      r_ptr     <= IDX_WIDTH'(NUM_INT_BDS - 1);
      r_pending <= '0;
      r_busy    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req_idx <= w_req_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      // A new start wins over the grant clearing the same BD.
      r_pending <= (r_pending & ~w_grant_mask) | startDMAOp;
      // A grant wins over a completion naming the same BD.
      r_busy    <= (r_busy & ~w_done_mask) | w_grant_mask;
    end
  end

`ifdef COREAXI4DMA_START_OVERRUN_EN
  logic [NUM_INT_BDS-1:0] r_overrun;

  // A start on a pending BD that is not leaving pending this cycle was
  // merged away; flag it. Set wins over a coincident clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (r_overrun & ~overrunClr) |
                   (startDMAOp & r_pending & ~w_grant_mask);
    end
  end

  assign overrun = r_overrun;
`else
  logic [NUM_INT_BDS-1:0] w_unused_overrun_clr;
  assign w_unused_overrun_clr = overrunClr;
  assign overrun = '0;
`endif

  assign reqValid  = (r_state == ST_OFFER);
  assign reqIdx    = r_req_idx;
  assign pending   = r_pending;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_coreaxi4dma_start_op_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for coreaxi4dma_start_op_arbiter (4 BDs, 3-bit indices so that an
// out-of-range opDoneIdx and the zero high index bit can be exercised).
// Inputs change 1 time unit after a rising edge; outputs are checked there
// too, after the edge that consumed the previous inputs. Grants are observed
// on the falling edge and matched against an expected-index queue.
// ---------------------------------------------------------------------------
module tb_coreaxi4dma_start_op_arbiter;

  localparam int NB = 4;
  localparam int IW = 3;

`ifdef COREAXI4DMA_START_OVERRUN_EN
  localparam logic [NB-1:0] OVR_BD3 = 4'b1000;
`else
  localparam logic [NB-1:0] OVR_BD3 = 4'b0000;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [NB-1:0] startDMAOp = '0;
  logic          reqValid;
  logic [IW-1:0] reqIdx;
  logic          reqReady = 1'b0;
  logic          opDone = 1'b0;
  logic [IW-1:0] opDoneIdx = '0;
  logic [NB-1:0] pending;
  logic [NB-1:0] busy;
  logic [NB-1:0] overrun;
  logic [NB-1:0] overrunClr = '0;
  logic          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] mon_exp;

  coreaxi4dma_start_op_arbiter #(.NUM_INT_BDS(NB), .IDX_WIDTH(IW)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .startDMAOp (startDMAOp),
    .reqValid   (reqValid),
    .reqIdx     (reqIdx),
    .reqReady   (reqReady),
    .opDone     (opDone),
    .opDoneIdx  (opDoneIdx),
    .pending    (pending),
    .busy       (busy),
    .overrun    (overrun),
    .overrunClr (overrunClr),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then land 1 unit after the consuming edge.
  task automatic cyc(input logic [NB-1:0] s, input logic rdy, input logic d,
                     input logic [IW-1:0] di, input logic [NB-1:0] clr);
    startDMAOp = s;
    reqReady   = rdy;
    opDone     = d;
    opDoneIdx  = di;
    overrunClr = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc('0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle();
    resetn = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [IW-1:0] idx,
                           input logic [NB-1:0] p, input logic [NB-1:0] b);
    check({tag, "_valid"}, 32'(reqValid), 32'(v));
    check({tag, "_state"}, 32'(dbg_state), 32'(v));
    if (v) check({tag, "_idx"}, 32'(reqIdx), 32'(idx));
    check({tag, "_pending"}, 32'(pending), 32'(p));
    check({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  // scoreboard: every handshake must match the head of the expected queue
  always @(negedge clock) begin
    if (resetn && reqValid && reqReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL grant_unexpected: got idx %0d, expected no grant", reqIdx);
      end else begin
        mon_exp = exp_q.pop_front();
        check("grant_idx", 32'(reqIdx), 32'(mon_exp));
      end
    end
  end

  typedef struct {
    logic          rst_n;
    logic [NB-1:0] start;
    logic          ready;
    logic          done;
    logic [IW-1:0] didx;
    logic          exp_valid;
    logic [IW-1:0] exp_idx;
    logic [NB-1:0] exp_pend;
    logic [NB-1:0] exp_busy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // single start on BD0, grant, completion, stray completion
    vecs[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0001, 4'b0000};
    vecs[2]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 4'b0001, 4'b0000};
    vecs[3]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0000, 4'b0001};
    vecs[4]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 4'b0000, 4'b0000};
    // reset, then three simultaneous starts with reqReady held high
    vecs[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0000, 4'b0000};
    vecs[7]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'b1011, 4'b0000};
    vecs[8]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 4'b1011, 4'b0000};
    vecs[9]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'b1010, 4'b0001};
    vecs[10] = '{1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 4'b1010, 4'b0001};
    vecs[11] = '{1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'b1000, 4'b0011};
    vecs[12] = '{1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b1, 3'd3, 4'b1000, 4'b0011};
    vecs[13] = '{1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0000, 4'b1011};
    vecs[14] = '{1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0000, 4'b1011};

    exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);

    for (int i = 0; i < 15; i++) begin
      resetn = vecs[i].rst_n;
      cyc(vecs[i].start, vecs[i].ready, vecs[i].done, vecs[i].didx, '0);
      check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx,
                vecs[i].exp_pend, vecs[i].exp_busy);
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(0));
    end
    resetn = 1'b1;

    // busy BD waits for its completion; out-of-range opDoneIdx ignored
    do_reset();
    check_out("t3_reset", 1'b0, 3'd0, 4'b0000, 4'b0000);
    cyc(4'b0100, 1'b0, 1'b0, '0, '0);
    idle();
    check_out("t3_offer", 1'b1, 3'd2, 4'b0100, 4'b0000);
    exp_q.push_back(3'd2);
    cyc('0, 1'b1, 1'b0, '0, '0);
    check_out("t3_grant", 1'b0, 3'd0, 4'b0000, 4'b0100);
    cyc(4'b0100, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check_out($sformatf("t3_blocked%0d", k), 1'b0, 3'd0, 4'b0100, 4'b0100);
    end
    cyc('0, 1'b0, 1'b1, 3'd6, '0);
    check_out("t3_oob_done", 1'b0, 3'd0, 4'b0100, 4'b0100);
    cyc('0, 1'b0, 1'b1, 3'd2, '0);
    check_out("t3_done", 1'b0, 3'd0, 4'b0100, 4'b0000);
    idle();
    check_out("t3_reoffer", 1'b1, 3'd2, 4'b0100, 4'b0000);
    check("t3_idx_full", 32'(reqIdx), 32'(3'b010));
    exp_q.push_back(3'd2);
    cyc('0, 1'b1, 1'b1, 3'd2, '0);
    check_out("t3_grant_and_done", 1'b0, 3'd0, 4'b0000, 4'b0100);
    cyc('0, 1'b0, 1'b1, 3'd2, '0);
    check_out("t3_final_done", 1'b0, 3'd0, 4'b0000, 4'b0000);

    // offer held stable under backpressure while another BD starts
    do_reset();
    cyc(4'b0010, 1'b0, 1'b0, '0, '0);
    idle();
    check_out("t4_offer", 1'b1, 3'd1, 4'b0010, 4'b0000);
    cyc(4'b0001, 1'b0, 1'b0, '0, '0);
    check_out("t4_hold0", 1'b1, 3'd1, 4'b0011, 4'b0000);
    for (int k = 1; k < 5; k++) begin
      idle();
      check_out($sformatf("t4_hold%0d", k), 1'b1, 3'd1, 4'b0011, 4'b0000);
    end
    exp_q.push_back(3'd1);
    cyc('0, 1'b1, 1'b0, '0, '0);
    check_out("t4_grant1", 1'b0, 3'd0, 4'b0001, 4'b0010);
    idle();
    check_out("t4_offer0", 1'b1, 3'd0, 4'b0001, 4'b0010);
    exp_q.push_back(3'd0);
    cyc(4'b0001, 1'b1, 1'b0, '0, '0);
    check_out("t4_start_and_grant", 1'b0, 3'd0, 4'b0001, 4'b0011);
    check("t4_no_overrun", 32'(overrun), 32'(0));
    idle();
    check_out("t4_wait_busy", 1'b0, 3'd0, 4'b0001, 4'b0011);
    cyc('0, 1'b0, 1'b1, 3'd0, '0);
    check_out("t4_done0", 1'b0, 3'd0, 4'b0001, 4'b0010);
    idle();
    check_out("t4_reoffer0", 1'b1, 3'd0, 4'b0001, 4'b0010);
    exp_q.push_back(3'd0);
    cyc('0, 1'b1, 1'b0, '0, '0);
    check_out("t4_grant0b", 1'b0, 3'd0, 4'b0000, 4'b0011);

    // overrun (sticky, set wins over clear); 0 when the feature is absent
    do_reset();
    cyc(4'b1000, 1'b0, 1'b0, '0, '0);
    check("t5_ovr_first", 32'(overrun), 32'(0));
    cyc(4'b1000, 1'b0, 1'b0, '0, '0);
    check("t5_ovr_set", 32'(overrun), 32'(OVR_BD3));
    check_out("t5_offer", 1'b1, 3'd3, 4'b1000, 4'b0000);
    cyc(4'b1000, 1'b0, 1'b0, '0, 4'b1000);
    check("t5_ovr_set_wins", 32'(overrun), 32'(OVR_BD3));
    cyc('0, 1'b0, 1'b0, '0, 4'b1000);
    check("t5_ovr_clr", 32'(overrun), 32'(0));
    exp_q.push_back(3'd3);
    cyc('0, 1'b1, 1'b0, '0, '0);
    check_out("t5_grant", 1'b0, 3'd0, 4'b0000, 4'b1000);

    // reset while offering with busy BDs, then a stale completion
    do_reset();
    cyc(4'b0110, 1'b0, 1'b0, '0, '0);
    idle();
    check_out("t6_offer1", 1'b1, 3'd1, 4'b0110, 4'b0000);
    exp_q.push_back(3'd1);
    cyc('0, 1'b1, 1'b0, '0, '0);
    idle();
    check_out("t6_offer2", 1'b1, 3'd2, 4'b0100, 4'b0010);
    exp_q.push_back(3'd2);
    cyc('0, 1'b1, 1'b0, '0, '0);
    cyc(4'b0001, 1'b0, 1'b0, '0, '0);
    idle();
    check_out("t6_offer0", 1'b1, 3'd0, 4'b0001, 4'b0110);
    resetn = 1'b0;
    idle();
    check_out("t6_reset", 1'b0, 3'd0, 4'b0000, 4'b0000);
    check("t6_reset_ovr", 32'(overrun), 32'(0));
    check("t6_reset_idx", 32'(reqIdx), 32'(0));
    resetn = 1'b1;
    cyc('0, 1'b0, 1'b1, 3'd1, '0);
    check_out("t6_stale_done", 1'b0, 3'd0, 4'b0000, 4'b0000);
    idle();
    check_out("t6_quiet", 1'b0, 3'd0, 4'b0000, 4'b0000);

    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
